// File: rtl/mem_io_bus_master.sv
// MEM-stage master for uncached IO accesses: legality check, bus arbitration,
// parity-protected command issue, completion timeout, read retry, single response.
module mem_io_bus_master #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] IO_BASE     = 32'h1FC0_0000,
  parameter logic [ADDR_W-1:0] IO_LIMIT    = 32'h1FFF_FFFF,
  parameter logic [ADDR_W-1:0] USER_LIMIT  = 32'h7FFF_FFFF,
  parameter logic [ADDR_W-1:0] TEXT_LIMIT  = 32'h0040_0000,
  parameter bit                PARITY_ODD  = 1'b0,
  parameter int                TIMEOUT_CYC = 256,
  parameter int                MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  // pipeline side
  input  logic              pipe_req_valid,
  output logic              pipe_req_ready,
  input  logic              pipe_rw,
  input  logic              pipe_um,
  input  logic [1:0]        pipe_size,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_resp_valid,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_addr_error,
  output logic              pipe_bus_error,
  // arbiter side
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_free,
  // command to the slave
  output logic              m_cmd_valid,
  output logic              m_rw,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W:0]   m_wdata,
  // slave completion
  input  logic              s_rd_valid,
  input  logic [DATA_W:0]   s_rdata,
  input  logic              s_wr_done,
  input  logic              s_bus_error,
  // FSM state for checkers
  output logic [2:0]        dbg_state
);

  // Handshakes: a request transfers on the clock edge where pipe_req_valid and
  // pipe_req_ready are both high; ready is only ever high in IDLE. The response,
  // the command strobe and bus_free are single-cycle pulses with no back-pressure.

  localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int RT_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST_V = TO_W'(TO_LAST);
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_XFER = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            state;
  logic              lat_rw;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [TO_W-1:0]   to_cnt;
  logic [RT_W-1:0]   retry_cnt;

  logic              addr_bad;
  logic              rd_par_ok;
  logic              to_hit;
  logic              wait_fin;
  logic              wait_err;
  logic              wait_retry;
  logic [DATA_W-1:0] wait_rdata;

  function automatic logic par_of(input logic [DATA_W-1:0] d);
    return PARITY_ODD ? ~^d : ^d;
  endfunction

  assign dbg_state = state;
  assign rd_par_ok = (s_rdata[DATA_W] == par_of(s_rdata[DATA_W-1:0]));
  assign to_hit    = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST_V);

  // Legality of the request currently offered by the pipeline.
  always_comb begin
    addr_bad = 1'b0;
    if (pipe_size == 2'b11) addr_bad = 1'b1;
    if ((pipe_size == 2'b01) && pipe_addr[0]) addr_bad = 1'b1;
    if ((pipe_size == 2'b10) && (pipe_addr[1:0] != 2'b00)) addr_bad = 1'b1;
    if ((pipe_addr < IO_BASE) || (pipe_addr > IO_LIMIT)) addr_bad = 1'b1;
    if (pipe_um && (pipe_addr > USER_LIMIT)) addr_bad = 1'b1;
    if (pipe_rw && (pipe_addr <= TEXT_LIMIT)) addr_bad = 1'b1;
  end

  // WAIT outcome: bus error beats completion, completion beats timeout.
  always_comb begin
    wait_fin   = 1'b0;
    wait_err   = 1'b0;
    wait_retry = 1'b0;
    if (s_bus_error) begin
      wait_fin = 1'b1;
      wait_err = 1'b1;
    end else if (lat_rw) begin
      if (s_wr_done) wait_fin = 1'b1;
    end else if (s_rd_valid) begin
      if (rd_par_ok) begin
        wait_fin = 1'b1;
      end else if (retry_cnt < RT_MAX) begin
        wait_retry = 1'b1;
      end else begin
        wait_fin = 1'b1;
        wait_err = 1'b1;
      end
    end
    if (!wait_fin && !wait_retry && to_hit) begin
      wait_fin = 1'b1;
      wait_err = 1'b1;
    end
    wait_rdata = (wait_err || lat_rw) ? '0 : s_rdata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      lat_rw          <= 1'b0;
      lat_size        <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      to_cnt          <= '0;
      retry_cnt       <= '0;
      pipe_req_ready  <= 1'b0;
      pipe_resp_valid <= 1'b0;
      pipe_rdata      <= '0;
      pipe_addr_error <= 1'b0;
      pipe_bus_error  <= 1'b0;
      bus_req         <= 1'b0;
      bus_free        <= 1'b0;
      m_cmd_valid     <= 1'b0;
      m_rw            <= 1'b0;
      m_size          <= '0;
      m_addr          <= '0;
      m_wdata         <= '0;
    end else begin
      pipe_resp_valid <= 1'b0;
      bus_free        <= 1'b0;
      m_cmd_valid     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pipe_req_valid && pipe_req_ready) begin
            lat_rw         <= pipe_rw;
            lat_size       <= pipe_size;
            lat_addr       <= pipe_addr;
            lat_wdata      <= pipe_wdata;
            pipe_req_ready <= 1'b0;
            if (addr_bad) begin
              state           <= S_RESP;
              pipe_resp_valid <= 1'b1;
              pipe_addr_error <= 1'b1;
            end else begin
              state   <= S_ARB;
              bus_req <= 1'b1;
            end
          end else begin
            pipe_req_ready <= 1'b1;
          end
        end
        S_ARB: begin
          if (bus_grant) begin
            state       <= S_XFER;
            m_cmd_valid <= 1'b1;
            m_rw        <= lat_rw;
            m_size      <= lat_size;
            m_addr      <= lat_addr;
            m_wdata     <= {par_of(lat_wdata), lat_wdata};
          end
        end
        S_XFER: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_fin) begin
            state           <= S_RESP;
            pipe_resp_valid <= 1'b1;
            pipe_bus_error  <= wait_err;
            pipe_rdata      <= wait_rdata;
            bus_req         <= 1'b0;
            bus_free        <= 1'b1;
          end else if (wait_retry) begin
            // Re-issue the held command; the bus stays owned across retries.
            retry_cnt   <= retry_cnt + 1'b1;
            state       <= S_XFER;
            m_cmd_valid <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RESP: begin
          state           <= S_IDLE;
          retry_cnt       <= '0;
          pipe_rdata      <= '0;
          pipe_addr_error <= 1'b0;
          pipe_bus_error  <= 1'b0;
          pipe_req_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
